data_mem_access_unit: RTL and testbench
=======================================

# data_mem_access_unit

Memory-stage access controller for the RV32IM pipeline. Consumes the decoded load/store control fields produced in ID (`mem_read[3:0]`, `mem_write[2:0]`) and performs the access against a word-wide, variable-latency data memory over a req/ack handshake. Generates byte lanes and store-data replication, extracts and sign/zero-extends load data, and stalls the pipeline via `busywait` until the access completes.

## Interface
Parameters:
- none (32-bit data, 30-bit word address, fixed)

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `mem_read`  in  4  [3]=load, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- `mem_write`  in  3  [2]=store, [1:0]=funct3[1:0] (00 SB, 01 SH, 10 SW)
- `address`  in  32  byte address from ALU
- `write_data`  in  32  rs2 store data
- `read_data`  out  32  extended load result, registered
- `busywait`  out  1  stall request to all pipeline registers
- `access_fault`  out  1  misaligned or reserved-encoding access, combinational
- `mem_req`  out  1  request to data memory, registered
- `mem_we`  out  1  1=write, 0=read, valid with `mem_req`
- `mem_addr`  out  30  word address (`address[31:2]`), latched
- `mem_wdata`  out  32  replicated store data, latched
- `mem_byte_en`  out  4  byte-lane enables, latched
- `mem_rdata`  in  32  word read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion pulse

## Operation
- access = `mem_read[3] | mem_write[2]`; if both set, store wins, load ignored.
- Fault: LH/LHU/SH with `address[0]`=1; LW/SW with `address[1:0]`≠0; load funct3 ∈ {011,110,111}; store funct3[1:0]=11. Faulting access: no transaction, `busywait`=0, `access_fault`=1 while presented in IDLE, `read_data` unchanged.
- FSM states IDLE, BUSY, DONE.
  - IDLE: access & !fault → BUSY; latch `mem_we`, `mem_addr`, `mem_wdata`, `mem_byte_en`, load funct3, `address[1:0]`.
  - BUSY: `mem_req`=1, all latched outputs held; `mem_ack` → DONE (load: capture extended data into `read_data`).
  - DONE: `busywait`=0 so the pipeline advances on this edge; unconditionally → IDLE. Prevents re-issuing the still-present instruction.
- `busywait` = (IDLE & access & !fault) | BUSY; combinational.
- Byte enables: SB `4'b0001 << address[1:0]`, data `{4{wd[7:0]}}`; SH `4'b0011 << {address[1],1'b0}`, data `{2{wd[15:0]}}`; SW `4'b1111`, data `wd`. Loads: `mem_byte_en`=`4'b1111`.
- Load extract: byte lane `address[1:0]`, halfword lane `address[1]`; funct3[2]=0 sign-extend, =1 zero-extend; LW passes word.
- `mem_ack` in IDLE/DONE ignored.

## Timing
- Reset (async, immediate): state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_byte_en`=0, `read_data`=0. `busywait`/`access_fault` follow inputs.
- Access presented cycle 0 → `busywait` high cycle 0; `mem_req` high from cycle 1; ack in cycle k (k≥1) → DONE in k+1, `read_data` valid from k+1, `busywait` low in k+1.
- Minimum occupancy 3 cycles (ack in cycle 1); `busywait` high exactly k+1 cycles.
- Back-to-back: next access seen in IDLE cycle after DONE; no idle bubble beyond DONE.
- Reset in BUSY: request dropped same instant; late `mem_ack` after reset ignored; memory must tolerate abandoned request.
- Inputs must be held stable while `busywait`=1 (guaranteed by stall).

## Test plan
- LB, address 0x103, mem_rdata 0x80AB_CDEF, ack cycle 1 → `read_data`=0xFFFF_FF80 in cycle 2, `busywait` high cycles 0–1 only.
- LHU, address 0x102, mem_rdata 0x8001_1234, ack delayed to cycle 4 → `read_data`=0x0000_8001 cycle 5, `mem_req` high cycles 1–4, `mem_addr`=0x40.
- SH, address 0x206, write_data 0xDEAD_BEEF → `mem_we`=1, `mem_byte_en`=4'b1100, `mem_wdata`=0xBEEF_BEEF; `read_data` unchanged.
- LW address 0x101 and store funct3 11 → `access_fault`=1, `busywait`=0, `mem_req` never asserted.
- Reset asserted mid-BUSY, ack arrives next cycle → `mem_req` drops at reset, state IDLE, `read_data`=0, ack ignored.
- Two consecutive SB (0x0,0xAA) then LB (0x0) → two write transactions, load returns 0xFFFF_FFAA, each with DONE cycle, no duplicate requests.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit
// Memory-stage access controller for the RV32IM pipeline. Takes the decoded
// load/store fields, runs one word-wide transaction against a variable-latency
// data memory over a req/ack handshake, and stalls the pipeline with busywait
// until the access completes.
//
// Ports
//   clk, reset      pipeline clock (rising edge), async active-high reset
//   mem_read[3:0]   [3]=load, [2:0]=funct3
//   mem_write[2:0]  [2]=store, [1:0]=funct3[1:0]
//   address         byte address from the ALU
//   write_data      rs2 store data
//   read_data       extended load result (registered)
//   busywait        stall request to the pipeline registers
//   access_fault    misaligned / reserved-encoding access (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_byte_en   memory request side
//   mem_rdata/mem_ack                               memory response side
// ----------------------------------------------------------------------------
module data_mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busywait,
    output logic        access_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_byte_en_q, mem_byte_en_d;
    logic [31:0] read_data_q, read_data_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  off_q, off_d;

    logic        is_store, is_load, access, fault, st_fault, ld_fault, start;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Store wins when both controls are set; the load is then ignored.
    assign is_store = mem_write[2];
    assign is_load  = mem_read[3] & ~is_store;
    assign access   = is_store | is_load;

    assign st_fault = is_store & ((mem_write[1:0] == 2'b11) |
                                  (mem_write[1:0] == 2'b01 & address[0]) |
                                  (mem_write[1:0] == 2'b10 & (|address[1:0])));
    assign ld_fault = is_load & ((mem_read[2:0] == 3'b011) |
                                 (mem_read[2:0] == 3'b110) |
                                 (mem_read[2:0] == 3'b111) |
                                 (mem_read[1:0] == 2'b01 & address[0]) |
                                 (mem_read[1:0] == 2'b10 & (|address[1:0])));
    assign fault    = st_fault | ld_fault;

    assign start        = (state_q == IDLE) & access & ~fault;
    assign busywait     = start | (state_q == BUSY);
    assign access_fault = (state_q == IDLE) & access & fault;

    // Store lane placement and data replication across the word.
    always_comb begin
        st_be   = 4'b1111;
        st_data = write_data;
        case (mem_write[1:0])
            2'b00: begin
                st_be   = 4'b0001 << address[1:0];
                st_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << {address[1], 1'b0};
                st_data = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the lane offset latched at issue, not the live bus.
    assign ld_byte = 8'(mem_rdata >> {off_q, 3'b000});
    assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (ld_f3_q[1:0])
            2'b00:   ld_ext = {{24{~ld_f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~ld_f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_byte_en_d = mem_byte_en_q;
        read_data_d   = read_data_q;
        ld_f3_d       = ld_f3_q;
        off_d         = off_q;
        case (state_q)
            IDLE: if (start) begin
                state_d       = BUSY;
                mem_req_d     = 1'b1;
                mem_we_d      = is_store;
                mem_addr_d    = address[31:2];
                mem_byte_en_d = is_store ? st_be : 4'b1111;
                // Write data only changes on stores; loads leave it as is.
                if (is_store) mem_wdata_d = st_data;
                ld_f3_d       = mem_read[2:0];
                off_d         = address[1:0];
            end
            BUSY: if (mem_ack) begin
                state_d   = DONE;
                mem_req_d = 1'b0;
                if (!mem_we_q) read_data_d = ld_ext;
            end
            // One cycle with busywait low lets the pipeline move past the
            // instruction that is still presented, so it is not re-issued.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_byte_en_q <= '0;
            read_data_q   <= '0;
            ld_f3_q       <= '0;
            off_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_byte_en_q <= mem_byte_en_d;
            read_data_q   <= read_data_d;
            ld_f3_q       <= ld_f3_d;
            off_q         <= off_d;
        end
    end

    assign read_data   = read_data_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_byte_en = mem_byte_en_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address, write_data, read_data, mem_rdata, mem_wdata;
    logic        busywait, access_fault, mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byte_en;

    data_mem_access_unit dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .busywait(busywait), .access_fault(access_fault), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs, maintained by the transaction-level model below.
    logic        e_busy = 0, e_fault = 0, e_req = 0, e_we = 0;
    logic [29:0] e_addr = 0;
    logic [31:0] e_wdata = 0, e_rd = 0;
    logic [3:0]  e_be = 0;
    logic        chk_on = 0;
    logic [31:0] mem_m [0:255];   // model of data memory, word indexed

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) if (chk_on) begin
        chk("busywait", 32'(busywait), 32'(e_busy));
        chk("access_fault", 32'(access_fault), 32'(e_fault));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_byte_en", 32'(mem_byte_en), 32'(e_be));
        chk("read_data", read_data, e_rd);
    end

    // ---- specification-level helpers ----
    function automatic int acc_size(input logic [1:0] f);
        return (f == 2'd0) ? 1 : (f == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_fault(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a);
        int off = int'(a % 4);
        if (mw[2]) return (mw[1:0] == 2'd3) || (off % acc_size(mw[1:0]) != 0);
        if (mr[3]) begin
            if (mr[2:0] == 3'd3 || mr[2:0] == 3'd6 || mr[2:0] == 3'd7) return 1;
            return off % acc_size(mr[1:0]) != 0;
        end
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] f, input logic [31:0] a);
        logic [3:0] be = 0;
        int sz = acc_size(f);
        for (int i = 0; i < 4; i++) if (i / sz == int'(a % 4) / sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] f, input logic [31:0] wd);
        logic [31:0] r = 0;
        int sz = acc_size(f);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz = acc_size(f3[1:0]);
        longint v = longint'((w >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1));
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        mem_read = 0; mem_write = 0; address = 0; write_data = 0;
    endtask

    // One complete access with the ack returned k cycles after presentation.
    task automatic do_access(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                             input logic [31:0] wd, input int k);
        bit st = mw[2];
        bit acc = mw[2] | mr[3];
        bit flt = m_fault(mr, mw, a);
        logic [7:0] wi = a[9:2];
        logic [3:0] be = st ? m_be(mw[1:0], a) : 4'b1111;
        logic [31:0] wdr = m_wdata(mw[1:0], wd);
        mem_read = mr; mem_write = mw; address = a; write_data = wd;
        e_busy = acc & ~flt; e_fault = acc & flt;
        if (!acc || flt) begin
            step; idle_inputs; e_busy = 0; e_fault = 0;
            return;
        end
        for (int c = 1; c <= k; c++) begin
            step;
            e_req = 1; e_busy = 1; e_fault = 0;
            e_we = st; e_addr = a[31:2]; e_be = be;
            if (st) e_wdata = wdr;
            if (c == k) begin mem_ack = 1; mem_rdata = mem_m[wi]; end
        end
        step;   // completion cycle: busywait drops, result visible
        mem_ack = 0; mem_rdata = 32'h0;
        e_req = 0; e_busy = 0;
        if (st) begin
            for (int i = 0; i < 4; i++) if (be[i]) mem_m[wi][8*i +: 8] = wdr[8*i +: 8];
        end else e_rd = m_load(mr[2:0], a, mem_m[wi]);
        step;
        idle_inputs;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        reset = 1; mem_ack = 0; mem_rdata = 0; idle_inputs;
        chk_on = 1;
        step; step;
        reset = 0;
        step;

        // LB 0x103, ack in cycle 1
        mem_m[8'h40] = 32'h80AB_CDEF;
        do_access(4'b1000, 3'b000, 32'h103, 32'h0, 1);
        chk("lit_lb", read_data, 32'hFFFF_FF80);

        // LHU 0x102, ack delayed to cycle 4
        mem_m[8'h40] = 32'h8001_1234;
        do_access(4'b1101, 3'b000, 32'h102, 32'h0, 4);
        chk("lit_lhu", read_data, 32'h0000_8001);
        chk("lit_lhu_addr", 32'(mem_addr), 32'h40);

        // SH 0x206, ack delay 2; read_data untouched
        do_access(4'b0000, 3'b101, 32'h206, 32'hDEAD_BEEF, 2);
        chk("lit_sh_be", 32'(mem_byte_en), 32'hC);
        chk("lit_sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("lit_sh_rd", read_data, 32'h0000_8001);

        // Faulting accesses: LW misaligned, store funct3 11, LH odd, reserved load
        do_access(4'b1010, 3'b000, 32'h101, 32'h0, 1);
        do_access(4'b0000, 3'b111, 32'h0, 32'h1234, 1);
        do_access(4'b1001, 3'b000, 32'h33, 32'h0, 1);
        do_access(4'b1011, 3'b000, 32'h40, 32'h0, 1);
        do_access(4'b1110, 3'b000, 32'h40, 32'h0, 1);

        // Load and store together: store wins, so misaligned LW does not fault
        do_access(4'b1010, 3'b100, 32'h301, 32'h0000_0077, 1);
        chk("lit_both_be", 32'(mem_byte_en), 32'h2);

        // Stray ack while idle is ignored
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        step;
        mem_ack = 0; mem_rdata = 0;
        step;

        // Back-to-back: SB, SB, LB with no gap between accesses
        do_access(4'b0000, 3'b100, 32'h0, 32'h0000_00AA, 1);
        do_access(4'b0000, 3'b100, 32'h0, 32'h0000_00AA, 3);
        do_access(4'b1000, 3'b000, 32'h0, 32'h0, 1);
        chk("lit_sb_lb", read_data, 32'hFFFF_FFAA);

        // LH sign-extend upper half, LW pass-through
        mem_m[8'h10] = 32'h8765_4321;
        do_access(4'b1001, 3'b000, 32'h42, 32'h0, 2);
        chk("lit_lh", read_data, 32'hFFFF_8765);
        do_access(4'b1010, 3'b000, 32'h40, 32'h0, 1);
        chk("lit_lw", read_data, 32'h8765_4321);

        // Reset in the middle of a busy load; late ack afterwards is ignored
        mem_read = 4'b1010; address = 32'h100; e_busy = 1;
        step;
        e_req = 1; e_we = 0; e_addr = 30'h40; e_be = 4'hF;
        step;
        reset = 1; idle_inputs;
        e_busy = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_rd = 0;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'h0);
        step;
        reset = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
        step;
        mem_ack = 0; mem_rdata = 0;
        step;
        chk("lit_rst_rd", read_data, 32'h0);
        step;

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
